// File: rtl/seg6_scan_driver.sv
// Time-multiplexed 6-digit 7-segment scan driver with per-slot dead time,
// leading-zero blanking, decimal-point mask and once-per-frame input latching.
module seg6_scan_driver #(
    parameter int DIV            = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [23:0] seg6_export,
    input  logic        lz_blank,
    input  logic [5:0]  dp_mask,
    output logic [7:0]  seg_out,
    output logic [5:0]  dig_sel,
    output logic        frame_tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [7:0]    SEG_INV   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [5:0]    DIG_INV   = (DIG_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    generate
        if (DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= DIV) begin : g_bad_params
            $error("seg6_scan_driver: need DIV >= 2 and 0 <= BLANK_CYCLES < DIV");
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [23:0]   shadow_val;
    logic [5:0]    shadow_dp;

    logic          frame_start;
    logic [23:0]   src_val;
    logic [5:0]    src_dp;
    logic [3:0]    nib;
    logic          lz_hit;
    logic          slot_active;
    logic [7:0]    seg_next;
    logic [5:0]    dig_next;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // The capture cycle forwards the incoming value so a zero-length blank
    // window still shows the freshly latched frame.
    always_comb begin
        frame_start = (cnt == '0) && (idx == 3'd0);
        src_val     = frame_start ? seg6_export : shadow_val;
        src_dp      = frame_start ? dp_mask : shadow_dp;
        nib         = src_val[{idx, 2'b00} +: 4];
        lz_hit      = lz_blank && (idx != 3'd0) && ((src_val >> {idx, 2'b00}) == 24'd0);
        slot_active = (cnt >= CNT_BLANK);
        seg_next    = 8'h00;
        dig_next    = 6'h00;
        if (slot_active) begin
            seg_next = {src_dp[idx], lz_hit ? 7'h00 : decode(nib)};
            dig_next = 6'd1 << idx;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            cnt        <= '0;
            idx        <= 3'd0;
            shadow_val <= 24'd0;
            shadow_dp  <= 6'd0;
            seg_out    <= SEG_INV;
            dig_sel    <= DIG_INV;
            frame_tick <= 1'b0;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (frame_start) begin
                shadow_val <= seg6_export;
                shadow_dp  <= dp_mask;
            end
            seg_out    <= seg_next ^ SEG_INV;
            dig_sel    <= dig_next ^ DIG_INV;
            frame_tick <= frame_start;
        end
    end

endmodule

// File: tb/tb_seg6_scan_driver.sv
// Bench for seg6_scan_driver at DIV=8, BLANK_CYCLES=2, active-low pins:
// table-driven frame vectors plus hand sequences for latching and reset.
module tb_seg6_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 6 * DIV;

    logic        clk;
    logic        reset_reset;
    logic [23:0] seg6_export;
    logic        lz_blank;
    logic [5:0]  dp_mask;
    logic [7:0]  seg_out;
    logic [5:0]  dig_sel;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    // Scoreboard entries are {frame_tick, dig_sel, seg_out} at the pins.
    logic [14:0] exp_q[$];

    typedef struct {
        logic [23:0]     val;
        logic            lz;
        logic [5:0]      dp;
        logic [5:0][7:0] seg;
    } vec_t;

    vec_t vecs[7];

    seg6_scan_driver #(
        .DIV(DIV), .BLANK_CYCLES(BLANK), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk_clk(clk),
        .reset_reset(reset_reset),
        .seg6_export(seg6_export),
        .lz_blank(lz_blank),
        .dp_mask(dp_mask),
        .seg_out(seg_out),
        .dig_sel(dig_sel),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        check(name, {14'd0, got}, {14'd0, exp});
    endtask

    // Pin-level expectation for one full frame, all digits shown with segs.
    task automatic push_frame(input logic [5:0][7:0] segs);
        for (int k = 1; k <= FRAME; k++) begin
            int slot;
            int c;
            logic [5:0] dig;
            logic [7:0] sg;
            slot = (k - 1) / DIV;
            c    = (k - 1) % DIV;
            if (c < BLANK) begin
                dig = 6'h3F;
                sg  = 8'hFF;
            end else begin
                dig = ~(6'd1 << slot);
                sg  = segs[slot];
            end
            exp_q.push_back({(k == 1), dig, sg});
        end
    endtask

    task automatic run_check(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check_bit({name, "_underflow"}, 1'b1, 1'b0);
            end else begin
                check($sformatf("%s_c%0d", name, k), {frame_tick, dig_sel, seg_out}, exp_q.pop_front());
            end
        end
    endtask

    task automatic do_reset(input logic [23:0] val, input logic lz, input logic [5:0] dp);
        @(negedge clk);
        reset_reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", {frame_tick, dig_sel, seg_out}, {1'b0, 6'h3F, 8'hFF});
        seg6_export = val;
        lz_blank    = lz;
        dp_mask     = dp;
        reset_reset = 1'b0;
    endtask

    initial begin
        reset_reset = 1'b1;
        seg6_export = 24'd0;
        lz_blank    = 1'b0;
        dp_mask     = 6'd0;

        // Expected segment pins listed digit 5 first, digit 0 last.
        vecs[0] = '{24'h123456, 1'b0, 6'h00, {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}};
        vecs[1] = '{24'h000042, 1'b1, 6'h00, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h99, 8'hA4}};
        vecs[2] = '{24'h000042, 1'b0, 6'h00, {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h99, 8'hA4}};
        vecs[3] = '{24'h000000, 1'b1, 6'h20, {8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[4] = '{24'hABCDEF, 1'b0, 6'h15, {8'h88, 8'h03, 8'hC6, 8'h21, 8'h86, 8'h0E}};
        vecs[5] = '{24'h007890, 1'b1, 6'h00, {8'hFF, 8'hFF, 8'hF8, 8'h80, 8'h90, 8'hC0}};
        vecs[6] = '{24'h100000, 1'b1, 6'h02, {8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'h40, 8'hC0}};

        for (int v = 0; v < 7; v++) begin
            do_reset(vecs[v].val, vecs[v].lz, vecs[v].dp);
            push_frame(vecs[v].seg);
            run_check($sformatf("vec%0d", v), FRAME);
        end

        // Input change during the digit-3 slot must wait for the next frame.
        do_reset(24'h111111, 1'b0, 6'h00);
        push_frame({6{8'hF9}});
        push_frame({6{8'h8E}});
        run_check("latch_a", 28);
        seg6_export = 24'hFFFFFF;
        run_check("latch_b", 2 * FRAME - 28);

        // Reset in the digit-4 active window; restart must capture fresh data.
        do_reset(24'h123456, 1'b0, 6'h00);
        push_frame(vecs[0].seg);
        run_check("midrst_pre", 37);
        exp_q.delete();
        reset_reset = 1'b1;
        seg6_export = 24'h000007;
        @(negedge clk);
        check("midrst_inactive", {frame_tick, dig_sel, seg_out}, {1'b0, 6'h3F, 8'hFF});
        reset_reset = 1'b0;
        push_frame({8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF8});
        run_check("midrst_post", FRAME);

        // Free-running scan with random inputs: select/blank/tick structure.
        do_reset(24'h0, 1'b0, 6'h0);
        for (int k = 1; k <= 10 * FRAME; k++) begin
            int c;
            int slot;
            logic [5:0] exp_dig;
            @(negedge clk);
            c       = (k - 1) % DIV;
            slot    = ((k - 1) / DIV) % 6;
            exp_dig = (c < BLANK) ? 6'h3F : ~(6'd1 << slot);
            check_bit($sformatf("rand_onehot_k%0d", k), ($countones(~dig_sel) <= 1), 1'b1);
            check($sformatf("rand_dig_k%0d", k), {9'd0, dig_sel}, {9'd0, exp_dig});
            check_bit($sformatf("rand_tick_k%0d", k), frame_tick, ((k - 1) % FRAME) == 0);
            if (c < BLANK)
                check($sformatf("rand_blankseg_k%0d", k), {7'd0, seg_out}, 15'h00FF);
            seg6_export = $urandom_range(0, 24'hFFFFFF);
            dp_mask     = 6'($urandom_range(0, 63));
            lz_blank    = 1'($urandom_range(0, 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
